reand_bist_ctrl: RTL

Built-in self-test sequencer for the 8-input reduction-AND gate block. On `start` it drives every input pattern from 0 to 2^WIDTH-1 into the gate under test, one per cycle. It compares each response against an internally computed expected value after a configurable response latency, and accumulates a mismatch count, the first failing pattern and a serial signature. It sits between the fault-simulation harness and the gate instance, replacing testbench-driven pattern application.

---
 rtl/reand_bist_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/reand_bist_ctrl.sv
// BIST sequencer for the WIDTH-input reduction-AND gate block.
// Sweeps every input pattern and scores the gate responses.
module reand_bist_ctrl #(
    parameter int WIDTH   = 8,
    parameter int DUT_LAT = 0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic             i_dut_o,
    output logic [WIDTH-1:0] o_pat_out,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_pass,
    output logic [WIDTH:0]   o_err_cnt,
    output logic             o_fail_seen,
    output logic [WIDTH-1:0] o_first_fail,
    output logic [15:0]      o_signature
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Pipe is kept one deep when unused so the arrays stay legal.
    localparam int PD = (DUT_LAT == 0) ? 1 : DUT_LAT;
    localparam logic [1:0]       DRAIN_LAST = 2'(PD - 1);
    localparam logic [WIDTH-1:0] PAT_MAX    = '1;
    localparam logic [WIDTH:0]   ERR_MAX    = '1;

    logic [1:0]       r_state;
    logic [1:0]       r_drain;
    logic [WIDTH-1:0] r_pat;

    logic [PD-1:0]            r_pv;
    logic [PD-1:0]            r_pe;
    logic [PD-1:0][WIDTH-1:0] r_pp;

    logic [WIDTH:0]   r_err;
    logic             r_fail;
    logic [WIDTH-1:0] r_first;
    logic [15:0]      r_sig;

    logic             w_run;
    logic             w_go;
    logic             w_abort;
    logic             w_cmp_v;
    logic             w_cmp_e;
    logic [WIDTH-1:0] w_cmp_p;
    logic             w_miss;

    assign w_run   = (r_state == S_RUN);
    assign w_go    = (r_state == S_IDLE) && i_start && !i_abort;
    assign w_abort = i_abort && (w_run || (r_state == S_DRAIN));

    // Zero latency compares the live pattern; otherwise the pipe tail.
    assign w_cmp_v = (DUT_LAT == 0) ? w_run    : r_pv[PD-1];
    assign w_cmp_e = (DUT_LAT == 0) ? &r_pat   : r_pe[PD-1];
    assign w_cmp_p = (DUT_LAT == 0) ? r_pat    : r_pp[PD-1];
    assign w_miss  = w_cmp_v && (i_dut_o != w_cmp_e);

    // Sequencer: pattern sweep, drain countdown and done pulse.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_pat   <= '0;
            r_drain <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_go) begin
                        r_pat   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (i_abort) begin
                        r_state <= S_IDLE;
                    end else if (r_pat == PAT_MAX) begin
                        r_drain <= '0;
                        r_state <= (DUT_LAT == 0) ? S_DONE : S_DRAIN;
                    end else begin
                        r_pat <= r_pat + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (i_abort) begin
                        r_state <= S_IDLE;
                    end else if (r_drain == DRAIN_LAST) begin
                        r_state <= S_DONE;
                    end else begin
                        r_drain <= r_drain + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Expected-value pipe aligning each pattern with its late response.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pv <= '0;
            r_pe <= '0;
            r_pp <= '0;
        end else if (w_go || w_abort) begin
            r_pv <= '0;
        end else begin
            r_pv[0] <= w_run;
            r_pe[0] <= &r_pat;
            r_pp[0] <= r_pat;
            for (int i = 1; i < PD; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pe[i] <= r_pe[i-1];
                r_pp[i] <= r_pp[i-1];
            end
        end
    end

    // Result accumulation: error count, first failure, signature.
    always_ff @(posedge i_clk) begin
        if (i_rst || w_go) begin
            r_err   <= '0;
            r_fail  <= 1'b0;
            r_first <= '0;
            r_sig   <= '0;
        end else if (w_cmp_v) begin
            r_sig <= {r_sig[14:0],
                      r_sig[15] ^ r_sig[13] ^ r_sig[12] ^ r_sig[10] ^ i_dut_o};
            if (w_miss) begin
                if (r_err != ERR_MAX) begin
                    r_err <= r_err + 1'b1;
                end
                if (!r_fail) begin
                    r_fail  <= 1'b1;
                    r_first <= w_cmp_p;
                end
            end
        end
    end

    assign o_pat_out    = r_pat;
    assign o_busy       = w_run || (r_state == S_DRAIN);
    assign o_done       = (r_state == S_DONE);
    assign o_pass       = (r_err == '0);
    assign o_err_cnt    = r_err;
    assign o_fail_seen  = r_fail;
    assign o_first_fail = r_first;
    assign o_signature  = r_sig;

endmodule
